// File: rtl/score_display_pkg.sv
// Shared screen geometry, colour constants and note-entry layout for the
// score display and the raster timing generator that drives it.
package score_display_pkg;

    localparam int SCR_WIDTH   = 800;
    localparam int SCR_HEIGHT  = 480;
    localparam int SCR_START_X = 88;
    localparam int SCR_START_Y = 32;

    localparam int X_BITS = 11;
    localparam int Y_BITS = 10;

    localparam logic [23:0] COLOR_BG       = 24'hFFFFFF;
    localparam logic [23:0] COLOR_NOTE     = 24'h000000;
    localparam logic [23:0] COLOR_PLAYHEAD = 24'hFF0000;

    // Entry layout is {note, start, duration} with the note in the MSBs.
    localparam int ENTRY_DUR_LSB = 0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic int entry_start_lsb(input int beat_bits);
        return beat_bits;
    endfunction

    function automatic int entry_note_lsb(input int beat_bits);
        return 2 * beat_bits;
    endfunction

    function automatic int entry_width(input int note_bits, input int beat_bits);
        return note_bits + 2 * beat_bits;
    endfunction

    function automatic rgb_t to_rgb(input logic [23:0] color);
        return rgb_t'(color);
    endfunction

endpackage

// File: rtl/score_display_note.sv
// Combinational hit test of one note entry against the current window-relative
// pixel: pitch row match plus a signed, clipped horizontal span match.
module note_hit
    import score_display_pkg::*;
#(
    parameter int BEAT_BITS  = 16,
    parameter int NOTE_BITS  = 7,
    parameter int TICK_PX    = 4,
    parameter int ROW_HEIGHT = 8,
    parameter int NOTE_TOP   = 84
) (
    input  logic [entry_width(NOTE_BITS, BEAT_BITS)-1:0] entry,
    input  logic [BEAT_BITS-1:0]                         beat,
    input  logic [X_BITS-1:0]                            xr,
    input  logic [Y_BITS-1:0]                            yr,
    output logic                                         hit
);

    localparam int START_LSB = entry_start_lsb(BEAT_BITS);
    localparam int NOTE_LSB  = entry_note_lsb(BEAT_BITS);
    localparam int TW        = BEAT_BITS + 1;
    localparam int PW        = BEAT_BITS + 12;

    logic [NOTE_BITS-1:0]   note_s;
    logic [BEAT_BITS-1:0]   start_s;
    logic [BEAT_BITS-1:0]   dur_s;
    logic signed [TW-1:0]   d_start_s;
    logic signed [TW-1:0]   d_end_s;
    logic signed [PW-1:0]   px_lo_s;
    logic signed [PW-1:0]   px_hi_s;
    logic signed [PW-1:0]   x_s;
    logic [31:0]            row_lo_s;
    logic                   note_ok_s;
    logic                   x_hit_s;
    logic                   y_hit_s;

    assign note_s  = entry[NOTE_LSB +: NOTE_BITS];
    assign start_s = entry[START_LSB +: BEAT_BITS];
    assign dur_s   = entry[ENTRY_DUR_LSB +: BEAT_BITS];

    // Tick offsets wrap modulo 2^(BEAT_BITS+1) and are read as signed, so spans
    // left of the playhead origin clip instead of reappearing at the right edge.
    always_comb begin
        d_start_s = $signed({1'b0, start_s} - {1'b0, beat});
        d_end_s   = $signed({1'b0, start_s} + {1'b0, dur_s} - {1'b0, beat});
        px_lo_s   = PW'(d_start_s) * PW'(TICK_PX);
        px_hi_s   = PW'(d_end_s) * PW'(TICK_PX);
        x_s       = PW'($signed({1'b0, xr}));
        x_hit_s   = (x_s >= px_lo_s) && (x_s < px_hi_s);

        note_ok_s = (note_s != {NOTE_BITS{1'b0}}) && (32'(note_s) <= 32'(NOTE_TOP));
        row_lo_s  = (32'(NOTE_TOP) - 32'(note_s)) * 32'(ROW_HEIGHT);
        y_hit_s   = (32'(yr) >= row_lo_s) && (32'(yr) < row_lo_s + 32'(ROW_HEIGHT));

        hit = note_ok_s && y_hit_s && x_hit_s;
    end

endmodule

// File: rtl/score_display.sv
// Piano-roll score overlay: double-buffered note set committed at frame start,
// and a fixed three-stage pixel pipeline producing rgb aligned with de_out.
module score_display
    import score_display_pkg::*;
#(
    parameter int          SCREEN_WIDTH       = SCR_WIDTH,
    parameter int          SCREEN_HEIGHT      = SCR_HEIGHT,
    parameter int          SCREEN_START_X     = SCR_START_X,
    parameter int          SCREEN_START_Y     = SCR_START_Y,
    parameter int          DISPLAYED_BEATS    = 4,
    parameter int          SIMULTANEOUS_NOTES = 4,
    parameter int          BEAT_DURATION      = 48,
    parameter int          BEAT_BITS          = 16,
    parameter int          NOTE_BITS          = 7,
    parameter int          TICK_PX            = 4,
    parameter int          ROW_HEIGHT         = 8,
    parameter int          NOTE_TOP           = 84,
    parameter int          PLAYHEAD_X         = 16,
    parameter logic [23:0] BG_COLOR           = COLOR_BG,
    parameter logic [23:0] NOTE_COLOR         = COLOR_NOTE,
    parameter logic [23:0] PLAYHEAD_COLOR     = COLOR_PLAYHEAD
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [X_BITS-1:0]     x,
    input  logic [Y_BITS-1:0]     y,
    input  logic                  de,
    input  logic                  frame_start,
    input  logic [2*DISPLAYED_BEATS*SIMULTANEOUS_NOTES-1:0]
                 [entry_width(NOTE_BITS, BEAT_BITS)-1:0] notes,
    input  logic                  notes_valid,
    output logic                  notes_ready,
    input  logic [BEAT_BITS-1:0]  cur_beat,
    output logic [7:0]            r,
    output logic [7:0]            g,
    output logic [7:0]            b,
    output logic                  de_out,
    output logic                  live
);

    localparam int N  = 2 * DISPLAYED_BEATS * SIMULTANEOUS_NOTES;
    localparam int EW = entry_width(NOTE_BITS, BEAT_BITS);

    if (BEAT_DURATION < 1) begin : g_bad_beat_duration
        $error("score_display: BEAT_DURATION must be positive");
    end

    logic [N-1:0][EW-1:0]  shadow_r;
    logic [N-1:0][EW-1:0]  live_set_r;
    logic                  shadow_empty_r;
    logic                  live_r;
    logic [BEAT_BITS-1:0]  frame_beat_r;
    logic                  capture_s;
    logic                  commit_s;

    logic [X_BITS-1:0]     xr1_r;
    logic [Y_BITS-1:0]     yr1_r;
    logic                  win1_r;
    logic                  de1_r;
    logic                  win_s;

    logic [N-1:0]          hit_s;
    logic [N-1:0]          hit2_r;
    logic [X_BITS-1:0]     xr2_r;
    logic                  win2_r;
    logic                  de2_r;
    logic                  live2_r;

    rgb_t                  pix_s;
    rgb_t                  rgb_r;
    logic                  de3_r;

    // Capture needs an empty shadow and commit needs a full one, so a capture
    // arriving with frame_start always waits for the following frame.
    assign capture_s = notes_valid && shadow_empty_r;
    assign commit_s  = frame_start && !shadow_empty_r;

    // Shadow/live note sets, live flag and per-frame beat sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r       <= {(N*EW){1'b0}};
            live_set_r     <= {(N*EW){1'b0}};
            shadow_empty_r <= 1'b1;
            live_r         <= 1'b0;
            frame_beat_r   <= {BEAT_BITS{1'b0}};
        end else begin
            if (capture_s) begin
                shadow_r       <= notes;
                shadow_empty_r <= 1'b0;
            end else if (commit_s) begin
                live_set_r     <= shadow_r;
                shadow_empty_r <= 1'b1;
                live_r         <= 1'b1;
            end
            if (frame_start) begin
                frame_beat_r <= cur_beat;
            end
        end
    end

    assign win_s = (x >= X_BITS'(SCREEN_START_X))
                && (x <  X_BITS'(SCREEN_START_X + SCREEN_WIDTH))
                && (y >= Y_BITS'(SCREEN_START_Y))
                && (y <  Y_BITS'(SCREEN_START_Y + SCREEN_HEIGHT));

    // Stage 1: window-relative coordinates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr1_r  <= {X_BITS{1'b0}};
            yr1_r  <= {Y_BITS{1'b0}};
            win1_r <= 1'b0;
            de1_r  <= 1'b0;
        end else begin
            xr1_r  <= x - X_BITS'(SCREEN_START_X);
            yr1_r  <= y - Y_BITS'(SCREEN_START_Y);
            win1_r <= win_s;
            de1_r  <= de;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_hit
        note_hit #(
            .BEAT_BITS  (BEAT_BITS),
            .NOTE_BITS  (NOTE_BITS),
            .TICK_PX    (TICK_PX),
            .ROW_HEIGHT (ROW_HEIGHT),
            .NOTE_TOP   (NOTE_TOP)
        ) u_note_hit (
            .entry (live_set_r[i]),
            .beat  (frame_beat_r),
            .xr    (xr1_r),
            .yr    (yr1_r),
            .hit   (hit_s[i])
        );
    end

    // Stage 2: per-entry hit vector plus the fields stage 3 still needs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit2_r  <= {N{1'b0}};
            xr2_r   <= {X_BITS{1'b0}};
            win2_r  <= 1'b0;
            de2_r   <= 1'b0;
            live2_r <= 1'b0;
        end else begin
            hit2_r  <= hit_s;
            xr2_r   <= xr1_r;
            win2_r  <= win1_r;
            de2_r   <= de1_r;
            live2_r <= live_r;
        end
    end

    // Colour priority: blanking, then playhead, then notes, then background.
    always_comb begin
        pix_s = to_rgb(BG_COLOR);
        if (!win2_r || !de2_r || !live2_r) begin
            pix_s = to_rgb(BG_COLOR);
        end else if ((xr2_r == X_BITS'(PLAYHEAD_X)) || (xr2_r == X_BITS'(PLAYHEAD_X + 1))) begin
            pix_s = to_rgb(PLAYHEAD_COLOR);
        end else if (|hit2_r) begin
            pix_s = to_rgb(NOTE_COLOR);
        end else begin
            pix_s = to_rgb(BG_COLOR);
        end
    end

    // Stage 3: registered pixel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_r <= to_rgb(BG_COLOR);
            de3_r <= 1'b0;
        end else begin
            rgb_r <= pix_s;
            de3_r <= de2_r;
        end
    end

    assign r           = rgb_r.r;
    assign g           = rgb_r.g;
    assign b           = rgb_r.b;
    assign de_out      = de3_r;
    assign live        = live_r;
    assign notes_ready = shadow_empty_r;

endmodule

// File: tb/tb_score_display.sv
// Randomised self-checking bench for score_display against a behavioural
// model of the note-set handshake and the pixel colour rules.
module tb_score_display;
    import score_display_pkg::*;

    localparam int N  = 32;
    localparam int EW = 39;

    logic                 clk;
    logic                 rst_n;
    logic [10:0]          x;
    logic [9:0]           y;
    logic                 de;
    logic                 frame_start;
    logic [N-1:0][EW-1:0] notes;
    logic                 notes_valid;
    logic                 notes_ready;
    logic [15:0]          cur_beat;
    logic [7:0]           r;
    logic [7:0]           g;
    logic [7:0]           b;
    logic                 de_out;
    logic                 live;

    score_display dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .x           (x),
        .y           (y),
        .de          (de),
        .frame_start (frame_start),
        .notes       (notes),
        .notes_valid (notes_valid),
        .notes_ready (notes_ready),
        .cur_beat    (cur_beat),
        .r           (r),
        .g           (g),
        .b           (b),
        .de_out      (de_out),
        .live        (live)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    int st_note[N], st_start[N], st_dur[N];
    int sh_note[N], sh_start[N], sh_dur[N];
    int lv_note[N], lv_start[N], lv_dur[N];
    bit m_full, m_live;
    int m_beat;

    typedef struct {
        int          cyc;
        logic [23:0] rgb;
        logic        de;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int wrap17(input int v);
        int w;
        w = v & 32'h1FFFF;
        if (w >= 65536) w = w - 131072;
        return w;
    endfunction

    function automatic logic [23:0] exp_color(input int px, input int py, input bit pde);
        int xr, yr, row, ds, dn;
        if (!pde || !m_live) return COLOR_BG;
        if (px < SCR_START_X || px >= SCR_START_X + SCR_WIDTH) return COLOR_BG;
        if (py < SCR_START_Y || py >= SCR_START_Y + SCR_HEIGHT) return COLOR_BG;
        xr = px - SCR_START_X;
        yr = py - SCR_START_Y;
        if (xr == 16 || xr == 17) return COLOR_PLAYHEAD;
        for (int i = 0; i < N; i++) begin
            if (lv_note[i] == 0 || lv_note[i] > 84) continue;
            row = (84 - lv_note[i]) * 8;
            if (yr < row || yr >= row + 8) continue;
            ds = wrap17(lv_start[i] - m_beat);
            dn = wrap17(lv_start[i] + lv_dur[i] - m_beat);
            if (xr >= ds * 4 && xr < dn * 4) return COLOR_NOTE;
        end
        return COLOR_BG;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            sh_note[i] = 0; sh_start[i] = 0; sh_dur[i] = 0;
            lv_note[i] = 0; lv_start[i] = 0; lv_dur[i] = 0;
        end
        m_full = 1'b0;
        m_live = 1'b0;
        m_beat = 0;
    endtask

    task automatic clear_stage();
        for (int i = 0; i < N; i++) begin
            st_note[i] = 0; st_start[i] = 0; st_dur[i] = 0;
        end
    endtask

    task automatic rand_stage(input int beat);
        for (int i = 0; i < N; i++) begin
            st_note[i]  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 100));
            st_start[i] = (beat + int'($urandom_range(0, 260)) - 60) & 32'hFFFF;
            st_dur[i]   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 65535))
                                                      : int'($urandom_range(0, 70));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            de = 1'b0;
        end
    endtask

    // One handshake/frame cycle; the model applies both events with the
    // shadow state as it was before the edge.
    task automatic edge_ops(input bit valid, input bit frame, input int beat);
        bit was_full;
        idle(4);
        check("notes_ready", 32'(notes_ready), 32'(!m_full));
        for (int i = 0; i < N; i++)
            notes[i] = {7'(st_note[i]), 16'(st_start[i]), 16'(st_dur[i])};
        notes_valid = valid;
        frame_start = frame;
        cur_beat    = 16'(beat);
        was_full    = m_full;
        if (frame) begin
            m_beat = beat;
            if (was_full) begin
                lv_note = sh_note; lv_start = sh_start; lv_dur = sh_dur;
                m_full  = 1'b0;
                m_live  = 1'b1;
            end
        end
        if (valid && !was_full) begin
            sh_note = st_note; sh_start = st_start; sh_dur = st_dur;
            m_full  = 1'b1;
        end
        @(negedge clk);
        notes_valid = 1'b0;
        frame_start = 1'b0;
        check("notes_ready_after", 32'(notes_ready), 32'(!m_full));
        check("live", 32'(live), 32'(m_live));
    endtask

    task automatic pix(input int px, input int py, input bit pde);
        exp_t e;
        @(negedge clk);
        x  = 11'(px);
        y  = 10'(py);
        de = pde;
        e.cyc = cyc + 3;
        e.rgb = exp_color(px, py, pde);
        e.de  = pde;
        exp_q.push_back(e);
    endtask

    task automatic rand_pixels(input int n);
        int i, nt, px, py;
        for (int k = 0; k < n; k++) begin
            i  = int'($urandom_range(0, N - 1));
            nt = ($urandom_range(0, 1) == 0) ? lv_note[i] : sh_note[i];
            if (nt >= 1 && nt <= 84 && $urandom_range(0, 3) != 0)
                py = SCR_START_Y + (84 - nt) * 8 + int'($urandom_range(0, 7));
            else
                py = int'($urandom_range(0, 620));
            if ($urandom_range(0, 1) == 0)
                px = SCR_START_X + 4 * wrap17(lv_start[i] - m_beat) + int'($urandom_range(0, 120)) - 20;
            else
                px = int'($urandom_range(0, 1000));
            if (px < 0) px = 0;
            if (px > 2047) px = 2047;
            pix(px, py, $urandom_range(0, 9) != 0);
        end
    endtask

    // Output monitor: compares each pixel three cycles after it was driven.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                check("rgb", 32'({r, g, b}), 32'(e.rgb));
                check("de_out", 32'(de_out), 32'(e.de));
            end
        end
    end

    initial begin
        rst_n = 1'b0; x = 11'd0; y = 10'd0; de = 1'b0; frame_start = 1'b0;
        notes = '0; notes_valid = 1'b0; cur_beat = 16'd0;
        model_reset();
        clear_stage();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rgb", 32'({r, g, b}), 32'h00FFFFFF);
        check("rst_de_out", 32'(de_out), 32'd0);
        check("rst_ready", 32'(notes_ready), 32'd1);
        check("rst_live", 32'(live), 32'd0);
        rst_n = 1'b1;

        // No commit yet: background everywhere, de_out tracks de
        for (int k = 0; k < 24; k++) pix(80 + k * 7, 200 + k, k % 3 != 0);
        idle(4);
        check("no_commit_live", 32'(live), 32'd0);

        // Single note {60,96,48} at beat 96
        clear_stage();
        st_note[0] = 60; st_start[0] = 96; st_dur[0] = 48;
        edge_ops(1'b1, 1'b0, 0);
        edge_ops(1'b0, 1'b1, 96);
        for (int k = 0; k < 24; k++) pix(88 + k, 224, 1'b1);
        for (int k = 185; k < 196; k++) pix(88 + k, 224, 1'b1);
        pix(88, 224, 1'b1);
        pix(188, 32 + 191, 1'b1);
        pix(188, 32 + 199, 1'b1);
        pix(188, 32 + 200, 1'b1);

        // Shadow loaded but no frame_start for two frames
        clear_stage();
        st_note[1] = 50; st_start[1] = 100; st_dur[1] = 10;
        st_note[2] = 84; st_start[2] = 96;  st_dur[2] = 30;
        edge_ops(1'b1, 1'b0, 0);
        rand_pixels(60);
        for (int k = 0; k < 30; k++) pix(88 + 16 + k * 2, 32 + 272 + (k % 8), 1'b1);
        rand_pixels(60);
        edge_ops(1'b0, 1'b1, 96);
        for (int k = 0; k < 30; k++) pix(88 + 16 + k * 2, 32 + 272 + (k % 8), 1'b1);
        for (int k = 0; k < 30; k++) pix(88 + k * 5, 32 + (k % 8), 1'b1);

        // notes_valid coincident with frame_start
        clear_stage();
        st_note[3] = 72; st_start[3] = 90; st_dur[3] = 40;
        edge_ops(1'b1, 1'b1, 96);
        for (int k = 0; k < 40; k++) pix(88 + k * 3, 32 + 96 + (k % 8), 1'b1);
        for (int k = 0; k < 20; k++) pix(88 + k * 3, 32 + 272, 1'b1);
        edge_ops(1'b0, 1'b1, 96);
        for (int k = 0; k < 40; k++) pix(88 + k * 3, 32 + 96 + (k % 8), 1'b1);
        for (int k = 0; k < 20; k++) pix(88 + k * 3, 32 + 272, 1'b1);

        // Left clip: start 90, duration 20, beat 100
        clear_stage();
        st_note[5] = 70; st_start[5] = 90; st_dur[5] = 20;
        edge_ops(1'b1, 1'b0, 0);
        edge_ops(1'b0, 1'b1, 100);
        for (int k = 0; k < 46; k++) pix(88 + k, 32 + 112, 1'b1);
        for (int k = 780; k < 800; k++) pix(88 + k, 32 + 119, 1'b1);
        pix(887, 32 + 112, 1'b1);
        pix(888, 32 + 112, 1'b1);

        // Reset mid-line with shadow full
        clear_stage();
        st_note[6] = 60; st_start[6] = 96; st_dur[6] = 48;
        edge_ops(1'b1, 1'b0, 0);
        for (int k = 0; k < 8; k++) pix(88 + k, 224, 1'b1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        check("midrst_rgb", 32'({r, g, b}), 32'h00FFFFFF);
        check("midrst_de_out", 32'(de_out), 32'd0);
        check("midrst_ready", 32'(notes_ready), 32'd1);
        check("midrst_live", 32'(live), 32'd0);
        @(negedge clk);
        de = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        edge_ops(1'b0, 1'b1, 96);
        for (int k = 0; k < 30; k++) pix(88 + k * 4, 224, 1'b1);
        rand_pixels(40);

        // Randomised frames
        for (int it = 0; it < 16; it++) begin
            int beat;
            beat = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 150))
                                               : int'($urandom_range(0, 65535));
            rand_stage(beat);
            if ($urandom_range(0, 4) != 0)
                edge_ops(1'b1, $urandom_range(0, 1) == 1, beat);
            edge_ops(1'b0, 1'b1, beat);
            rand_pixels(150);
        end

        idle(5);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
